// File: rtl/tpu_host_sequencer.sv
// Avalon-MM master that runs one TPU matrix-multiply job: load weights/inputs, issue timed control writes, read results out.
// Define TPU_SEQ_PERF_EN to add a saturating busy-cycle counter on perf_cycles.
module tpu_host_sequencer #(
  parameter int DATA_WIDTH   = 64,
  parameter int WIDTH_HEIGHT = 16,
  parameter int FILL_CYCLES  = 32,
  parameter int DRAIN_CYCLES = 32,
  parameter int MULT_CYCLES  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  typedef enum logic [3:0] {
    IDLE, RST, LOAD_W, FILL, FILL_WAIT, DRAIN, DRAIN_WAIT,
    LOAD_I, MULT, MULT_WAIT, RD_REQ, RD_CAP, OUT, DONE
  } state_t;

  localparam logic [7:0]            LAST_IDX  = 8'(WIDTH_HEIGHT - 1);
  localparam logic [9:0]            ADDR_CTRL = 10'h000;
  localparam logic [1:0]            WIN_DATA  = 2'b01;
  localparam logic [1:0]            WIN_OUT   = 2'b11;
  localparam logic [DATA_WIDTH-1:0] CMD_RESET = DATA_WIDTH'(4'hF);
  localparam logic [DATA_WIDTH-1:0] CMD_FILL  = DATA_WIDTH'(4'h1);
  localparam logic [DATA_WIDTH-1:0] CMD_DRAIN = DATA_WIDTH'(4'h2);
  localparam logic [DATA_WIDTH-1:0] CMD_MULT  = DATA_WIDTH'(4'h3);

  state_t                  state_q, state_d;
  logic [7:0]              idx_q, idx_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [9:0]              m_address_q, m_address_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;
  logic [DATA_WIDTH-1:0]   m_writedata_q, m_writedata_d;

  logic       in_hs;
  logic       last_idx;
  logic [7:0] idx_inc;

  assign in_ready = (state_q == LOAD_W) || (state_q == LOAD_I);
  assign in_hs    = in_valid && in_ready;
  assign last_idx = (idx_q == LAST_IDX);
  assign idx_inc  = idx_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = RST;
      RST:        state_d = LOAD_W;
      LOAD_W:     if (in_hs && last_idx) state_d = FILL;
      FILL:       state_d = FILL_WAIT;
      FILL_WAIT:  if (cnt_q == 16'd0) state_d = DRAIN;
      DRAIN:      state_d = DRAIN_WAIT;
      DRAIN_WAIT: if (cnt_q == 16'd0) state_d = LOAD_I;
      LOAD_I:     if (in_hs && last_idx) state_d = MULT;
      MULT:       state_d = MULT_WAIT;
      MULT_WAIT:  if (cnt_q == 16'd0) state_d = RD_REQ;
      RD_REQ:     state_d = RD_CAP;
      RD_CAP:     state_d = OUT;
      OUT:        if (out_ready) state_d = last_idx ? DONE : RD_REQ;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Bus strobes are registered, so each one is computed the cycle before it appears.
  always_comb begin
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    m_address_d   = m_address_q;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_writedata_d = m_writedata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d        = 1'b1;
          m_write_d     = 1'b1;
          m_address_d   = ADDR_CTRL;
          m_writedata_d = CMD_RESET;
        end
      end
      RST: idx_d = 8'd0;
      LOAD_W, LOAD_I: begin
        if (in_hs) begin
          m_write_d     = 1'b1;
          m_address_d   = {WIN_DATA, idx_q};
          m_writedata_d = in_data;
          idx_d         = last_idx ? 8'd0 : idx_inc;
        end
      end
      FILL: begin
        m_write_d     = 1'b1;
        m_address_d   = ADDR_CTRL;
        m_writedata_d = CMD_FILL;
        cnt_d         = 16'(FILL_CYCLES);
      end
      DRAIN: begin
        m_write_d     = 1'b1;
        m_address_d   = ADDR_CTRL;
        m_writedata_d = CMD_DRAIN;
        cnt_d         = 16'(DRAIN_CYCLES);
      end
      MULT: begin
        m_write_d     = 1'b1;
        m_address_d   = ADDR_CTRL;
        m_writedata_d = CMD_MULT;
        cnt_d         = 16'(MULT_CYCLES);
      end
      FILL_WAIT, DRAIN_WAIT: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
      end
      MULT_WAIT: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          idx_d       = 8'd0;
          m_read_d    = 1'b1;
          m_address_d = {WIN_OUT, 8'd0};
        end
      end
      RD_CAP: begin
        out_data_d  = m_readdata;
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_idx) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            idx_d  = 8'd0;
          end else begin
            idx_d       = idx_inc;
            m_read_d    = 1'b1;
            m_address_d = {WIN_OUT, idx_inc};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q         <= 8'd0;
      cnt_q         <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      m_address_q   <= 10'd0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_writedata_q <= '0;
    end else begin
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      m_address_q   <= m_address_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign m_address    = m_address_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign m_byteenable = '1;

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start)               perf_d = 32'd0;
    else if (busy_q && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= 32'd0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Randomized self-checking bench for tpu_host_sequencer: bus-trace and result-stream scoreboard against a job-level model.
`timescale 1ns/1ps
module tb_tpu_host_sequencer;
  localparam int DW = 64;
  localparam int WH = 16;
  localparam int FC = 32;
  localparam int DC = 32;
  localparam int MC = 64;
  localparam int JOB_CYCLES = 2*WH + 3*WH + FC + DC + MC + 7;
  localparam int TRACE_LEN  = 1 + WH + 2 + WH + 1 + WH;

  logic          clk, reset, start, busy, done;
  logic [DW-1:0] in_data, out_data, m_writedata, m_readdata;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [9:0]    m_address;
  logic          m_read, m_write;
  logic [DW/8-1:0] m_byteenable;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;
  int busy_cycles = 0;
  bit            log_write[$];
  logic [9:0]    log_addr[$];
  logic [DW-1:0] log_data[$];
  logic [DW-1:0] src_words[2*WH];
  logic [DW-1:0] got_q[$];

  tpu_host_sequencer #(
    .DATA_WIDTH(DW), .WIDTH_HEIGHT(WH), .FILL_CYCLES(FC), .DRAIN_CYCLES(DC), .MULT_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_byteenable(m_byteenable)
`ifdef TPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: result window returns address*3, one cycle after the read strobe.
  always @(posedge clk) m_readdata <= m_read ? (64'(m_address) * 64'd3) : '0;

  always @(negedge clk) begin
    if (reset) begin
      if (done) done_count++;
      if (busy) busy_cycles++;
      if (m_write || m_read) begin
        log_write.push_back(m_write);
        log_addr.push_back(m_address);
        log_data.push_back(m_write ? m_writedata : '0);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src(input bit stall, input int nwords, input string tag);
    int k = 0;
    int cyc = 0;
    while (k < nwords && cyc < 5000) begin
      @(negedge clk);
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = src_words[k];
      if (in_valid && in_ready) k++;
      cyc++;
    end
    chk({tag, "_src_words"}, 128'(k), 128'(nwords));
  endtask

  task automatic drive_sink(input bit stall, input string tag);
    int k = 0;
    int cyc = 0;
    while (k < WH && cyc < 5000) begin
      @(negedge clk);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        $display("[%s] result %0d = %h", tag, k, out_data);
        got_q.push_back(out_data);
        k++;
      end
      cyc++;
    end
    chk({tag, "_sink_words"}, 128'(k), 128'(WH));
  endtask

  task automatic poke_start_in_mult(input int lb);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int j = lb; j < log_write.size(); j++)
        if (log_write[j] && log_addr[j] == 10'h000 && log_data[j] == 64'h3) seen = 1'b1;
    end
    chk("poke_mult_seen", 128'(seen), 128'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input bit stall, input bit poke);
    int lb, db, bb, n;
    bit            ew[$];
    logic [9:0]    ea[$];
    logic [DW-1:0] ed[$];
    for (int i = 0; i < 2*WH; i++) src_words[i] = {$urandom(), $urandom()};
    got_q.delete();
    @(negedge clk);
    lb = log_write.size();
    db = done_count;
    bb = busy_cycles;
    pulse_start();
    chk({tag, "_rst_write"}, 128'({busy, m_write, m_address, m_writedata}),
        128'({1'b1, 1'b1, 10'h000, 64'hF}));
`ifdef TPU_SEQ_PERF_EN
    chk({tag, "_perf_cleared"}, 128'(perf_cycles), 128'(0));
`endif
    fork
      drive_src(stall, 2*WH, tag);
      drive_sink(stall, tag);
      begin
        if (poke) poke_start_in_mult(lb);
      end
    join
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Expected job: reset cmd, weights, fill, drain, inputs, multiply, then result reads.
    ew.push_back(1'b1); ea.push_back(10'h000); ed.push_back(64'hF);
    for (int i = 0; i < WH; i++) begin ew.push_back(1'b1); ea.push_back(10'(10'h100 + i)); ed.push_back(src_words[i]); end
    ew.push_back(1'b1); ea.push_back(10'h000); ed.push_back(64'h1);
    ew.push_back(1'b1); ea.push_back(10'h000); ed.push_back(64'h2);
    for (int i = 0; i < WH; i++) begin ew.push_back(1'b1); ea.push_back(10'(10'h100 + i)); ed.push_back(src_words[WH+i]); end
    ew.push_back(1'b1); ea.push_back(10'h000); ed.push_back(64'h3);
    for (int i = 0; i < WH; i++) begin ew.push_back(1'b0); ea.push_back(10'(10'h300 + i)); ed.push_back('0); end

    n = log_write.size() - lb;
    chk({tag, "_trace_len"}, 128'(n), 128'(TRACE_LEN));
    for (int j = 0; j < ew.size() && j < n; j++)
      chk($sformatf("%s_bus%0d", tag, j), 128'({log_write[lb+j], log_addr[lb+j], log_data[lb+j]}),
          128'({ew[j], ea[j], ed[j]}));
    for (int i = 0; i < WH && i < got_q.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), 128'(got_q[i]), 128'((64'h300 + 64'(i)) * 64'd3));
    chk({tag, "_done_pulses"}, 128'(done_count - db), 128'(1));
    chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    if (!stall) chk({tag, "_job_cycles"}, 128'(busy_cycles - bb), 128'(JOB_CYCLES));
    $display("[%s] job complete: %0d bus ops, %0d results", tag, n, got_q.size());
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom(), $urandom()};
    end
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_m_strobes", 128'({m_read, m_write}), 128'(0));
    chk("rst_m_address", 128'(m_address), 128'(0));
    chk("rst_m_writedata", 128'(m_writedata), 128'(0));
    chk("rst_byteenable", 128'(m_byteenable), 128'(8'hFF));
`ifdef TPU_SEQ_PERF_EN
    chk("rst_perf", 128'(perf_cycles), 128'(0));
`endif
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_release", 128'({busy, in_ready, m_write, m_read}), 128'(0));

    run_job("nostall", 1'b0, 1'b0);
`ifdef TPU_SEQ_PERF_EN
    chk("perf_job", 128'(perf_cycles), 128'(JOB_CYCLES));
    repeat (10) @(negedge clk);
    chk("perf_hold", 128'(perf_cycles), 128'(JOB_CYCLES));
`endif
    run_job("stall", 1'b1, 1'b0);
    run_job("ignore_start", 1'b0, 1'b1);

    // Abort during input load, with the fifth input word's write on the bus.
    for (int i = 0; i < 2*WH; i++) src_words[i] = {$urandom(), $urandom()};
    pulse_start();
    drive_src(1'b0, WH + 5, "abort");
    @(posedge clk);
    #1;
    chk("abort_inflight", 128'({m_write, m_address}), 128'({1'b1, 10'h104}));
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_strobes", 128'({m_write, m_read}), 128'(0));
    chk("abort_addr_data", 128'({m_address, m_writedata}), 128'(0));
    chk("abort_status", 128'({busy, done, in_ready, out_valid}), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    run_job("after_abort", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
